sw_debounce: RTL and testbench



---
 rtl/sw_debounce.sv | 97 +++++++++
 tb/tb_sw_debounce.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Slide-switch conditioner for the NIOS II switch PIO.
// Each raw switch line is synchronised, then debounced against a shared
// prescaled sample tick: a new level is committed only after STABLE_TICKS
// consecutive ticks of disagreement with the committed level. Registered
// rise/fall/changed pulses line up with the cycle the level changes.
module sw_debounce #(
   parameter int WIDTH        = 10,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 20,
   parameter int SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed,
   output logic             tick
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = $clog2(STABLE_TICKS) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] cnt      [WIDTH];
   logic [CNT_W-1:0] cnt_next [WIDTH];
   logic [WIDTH-1:0] out_next;
   logic [WIDTH-1:0] rise_next;
   logic [WIDTH-1:0] fall_next;

   // Plain flop chain bringing the asynchronous pins into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= sw_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Free-running prescaler; tick marks its terminal count.
   always_ff @(posedge clk) begin
      if (reset)                  div_cnt <= '0;
      else if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                        div_cnt <= div_cnt + DIV_W'(1);
   end

   assign tick = (div_cnt == DIV_LAST);

   // Per-bit stability counting and commit decision; any return to the
   // committed level restarts the count, even between ticks.
   always_comb begin
      out_next  = sw_out;
      rise_next = '0;
      fall_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = cnt[i];
         if (s[i] == sw_out[i]) begin
            cnt_next[i] = '0;
         end else if (tick) begin
            if (cnt[i] == CNT_LAST) begin
               out_next[i]  = s[i];
               rise_next[i] = s[i];
               fall_next[i] = ~s[i];
               cnt_next[i]  = '0;
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Register the committed level, the counters and the aligned pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_out     <= '0;
         sw_rise    <= '0;
         sw_fall    <= '0;
         sw_changed <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         sw_out     <= out_next;
         sw_rise    <= rise_next;
         sw_fall    <= fall_next;
         sw_changed <= |(rise_next | fall_next);
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      end
   end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a small prescaler so the debounce
// window (11..14 edges after a raw change) is short. Expected commits are
// queued when the stimulus changes and retired when the DUT pulses.
module tb_sw_debounce;

   localparam int W  = 10;
   localparam int TD = 4;
   localparam int ST = 3;
   localparam int SS = 2;
   localparam int LAT_LO = SS + (ST - 1) * TD + 1;  // 11
   localparam int LAT_HI = SS + ST * TD;            // 14

   typedef struct {
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      int           lo;
      int           hi;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] sw_raw = '0;
   logic [W-1:0] sw_out, sw_rise, sw_fall;
   logic         sw_changed, tick;

   exp_t         exp_q[$];
   logic [W-1:0] exp_level = '0;
   int           cyc = 0;
   int           rst_edge = 0;
   int           n_tests = 0;
   int           n_fail = 0;

   sw_debounce #(
      .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_out(sw_out),
      .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed),
      .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc = cyc + 1;
      #1;
   endtask

   // Queue a commit expected for a raw change driven just after edge 'cyc'.
   task automatic expect_commit(input logic [W-1:0] r, input logic [W-1:0] f, input int base);
      exp_t e;
      e.rise = r;
      e.fall = f;
      e.lo   = base + LAT_LO;
      e.hi   = base + LAT_HI;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      rst_edge = cyc;
      exp_q.delete();
      exp_level = '0;
      chk("rst_sw_out", 32'(sw_out), 32'(0));
      chk("rst_pulses", {11'(0), sw_rise, sw_fall, sw_changed}, 32'(0));
      chk("rst_tick", 32'(tick), 32'(0));
      reset = 1'b0;
   endtask

   // Advance n cycles, checking tick phase, pulses and the level each cycle.
   task automatic run(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         step();
         chk("tick", 32'(tick), 32'(((cyc - rst_edge) % TD) == (TD - 1)));
         if (sw_changed || (|sw_rise) || (|sw_fall)) begin
            if (exp_q.size() == 0) begin
               chk("spurious_pulse", {11'(0), sw_rise, sw_fall, sw_changed}, 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk("sw_rise", 32'(sw_rise), 32'(e.rise));
               chk("sw_fall", 32'(sw_fall), 32'(e.fall));
               chk("sw_changed", 32'(sw_changed), 32'(1));
               chk("commit_in_window", 32'((cyc >= e.lo) && (cyc <= e.hi)), 32'(1));
               exp_level = (exp_level | e.rise) & ~e.fall;
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
            e = exp_q.pop_front();
            chk("commit_timeout", 32'(cyc), 32'(e.hi));
         end
         chk("sw_out", 32'(sw_out), 32'(exp_level));
      end
   endtask

   initial begin
      // Reset, then idle: no commits, tick every 4th cycle.
      step();
      do_reset();
      run(50);

      // All bits rise together, then all fall together.
      sw_raw = 10'h3FF;
      expect_commit(10'h3FF, 10'h000, cyc);
      run(20);
      sw_raw = 10'h000;
      expect_commit(10'h000, 10'h3FF, cyc);
      run(20);

      // Short glitch on bit 3 must be rejected.
      sw_raw[3] = 1'b1;
      run(6);
      sw_raw[3] = 1'b0;
      run(30);

      // Bounce on bit 5, then settle high.
      for (int k = 0; k < 14; k++) begin
         sw_raw[5] = (k % 2 == 0);
         run(3);
      end
      sw_raw[5] = 1'b1;
      expect_commit(10'h020, 10'h000, cyc);
      run(20);
      sw_raw[5] = 1'b0;
      expect_commit(10'h000, 10'h020, cyc);
      run(20);

      // Reset in the middle of a count discards the progress.
      sw_raw[0] = 1'b1;
      run(7);
      do_reset();
      expect_commit(10'h001, 10'h000, rst_edge);
      run(20);
      sw_raw[0] = 1'b0;
      expect_commit(10'h000, 10'h001, cyc);
      run(20);

      // Independent bits committing in separate windows.
      sw_raw[1] = 1'b1;
      expect_commit(10'h002, 10'h000, cyc);
      run(6);
      sw_raw[7] = 1'b1;
      expect_commit(10'h080, 10'h000, cyc);
      run(25);
      chk("queue_drained", 32'(exp_q.size()), 32'(0));
      chk("final_level", 32'(sw_out), 32'(10'h082));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
